// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: shadows the E/M/W pipeline to produce load-use / MD stalls
// and per-operand forwarding selects, plus a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int AW       = 5,
  parameter int TW       = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CW       = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_rs_tuse,
  input  logic [TW-1:0] d_rt_tuse,
  input  logic [AW-1:0] d_dst,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_md,
  input  logic          d_md_start,
  input  logic          d_md_div,
  output logic          stall,
  output logic [1:0]    fwd_d_rs,
  output logic [1:0]    fwd_d_rt,
  output logic [1:0]    fwd_e_rs,
  output logic [1:0]    fwd_e_rt,
  output logic [1:0]    fwd_m_rt,
  output logic          md_busy,
  output logic [15:0]   stall_cnt
);

  typedef struct packed {
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] dst;
    logic [TW-1:0] tnew;
  } slot_t;

  slot_t         e_q, m_q, w_q;
  slot_t         e_d, m_d, w_d;
  logic [CW-1:0] md_cnt_q, md_cnt_d;
  logic [15:0]   stall_cnt_q, stall_cnt_d;

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // A producer still in flight blocks the source if it won't be ready by use time.
  function automatic logic src_stall(input logic [AW-1:0] s, input logic [TW-1:0] tuse,
                                     input slot_t e, input slot_t m);
    return (s != '0) && (((e.dst == s) && (e.tnew > tuse)) ||
                         ((m.dst == s) && (m.tnew > tuse)));
  endfunction

  // Newest matching slot wins; a non-ready newest match masks older ready ones.
  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src, input slot_t e,
                                         input slot_t m, input slot_t w, input logic [2:0] en);
    logic [1:0] sel;
    sel = 2'd0;
    if (src != '0) begin
      if (en[0] && (e.dst == src))      sel = (e.tnew == '0) ? 2'd1 : 2'd0;
      else if (en[1] && (m.dst == src)) sel = (m.tnew == '0) ? 2'd2 : 2'd0;
      else if (en[2] && (w.dst == src)) sel = (w.tnew == '0) ? 2'd3 : 2'd0;
    end
    return sel;
  endfunction

  assign md_busy   = (md_cnt_q != '0);
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    stall = src_stall(d_rs, d_rs_tuse, e_q, m_q) ||
            src_stall(d_rt, d_rt_tuse, e_q, m_q) ||
            (d_md && md_busy);
    fwd_d_rs = fwd_sel(d_rs,   e_q, m_q, w_q, 3'b111);
    fwd_d_rt = fwd_sel(d_rt,   e_q, m_q, w_q, 3'b111);
    fwd_e_rs = fwd_sel(e_q.rs, e_q, m_q, w_q, 3'b110);
    fwd_e_rt = fwd_sel(e_q.rt, e_q, m_q, w_q, 3'b110);
    fwd_m_rt = fwd_sel(m_q.rt, e_q, m_q, w_q, 3'b100);
  end

  always_comb begin
    w_d      = m_q;
    w_d.tnew = dec_sat(m_q.tnew);
    m_d      = e_q;
    m_d.tnew = dec_sat(e_q.tnew);
    e_d      = '0;
    if (!stall) e_d = '{rs: d_rs, rt: d_rt, dst: d_dst, tnew: d_tnew};

    md_cnt_d = md_cnt_q;
    if (d_md_start && !stall) md_cnt_d = d_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    else if (md_busy)         md_cnt_d = md_cnt_q - 1'b1;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      w_q         <= w_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: instruction-age reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_hazard_scoreboard;
  localparam int AW = 5, TW = 2, MULT = 5, DIV = 10, CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] d_rs = '0, d_rt = '0, d_dst = '0;
  logic [TW-1:0] d_rs_tuse = '0, d_rt_tuse = '0, d_tnew = '0;
  logic          d_md = 1'b0, d_md_start = 1'b0, d_md_div = 1'b0;
  logic          stall, md_busy;
  logic [1:0]    fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;
  logic [15:0]   stall_cnt;

  hazard_scoreboard #(.AW(AW), .TW(TW), .MULT_CYC(MULT), .DIV_CYC(DIV), .CW(CW)) dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse),
    .d_rt_tuse(d_rt_tuse), .d_dst(d_dst), .d_tnew(d_tnew), .d_md(d_md),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .stall(stall),
    .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs),
    .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt), .md_busy(md_busy), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: last three instructions that entered E, indexed by age (0=E,1=M,2=W),
  // keeping the original tnew; remaining latency is tnew minus age.
  int     h_rs[3], h_rt[3], h_dst[3], h_tn[3];
  longint cyc = 0, md_done = 0;
  int     m_scnt = 0;

  function automatic int rem(input int a);
    return (h_tn[a] > a) ? h_tn[a] - a : 0;
  endfunction

  function automatic int efwd(input int src, input int from);
    for (int a = from; a < 3; a++)
      if (src != 0 && h_dst[a] == src) return (rem(a) == 0) ? a + 1 : 0;
    return 0;
  endfunction

  function automatic bit blocked(input int src, input int tuse);
    for (int a = 0; a < 2; a++)
      if (src != 0 && h_dst[a] == src && rem(a) > tuse) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    bit es, busy;
    if (reset) begin
      for (int a = 0; a < 3; a++) begin h_rs[a] = 0; h_rt[a] = 0; h_dst[a] = 0; h_tn[a] = 0; end
      md_done = 0;
      m_scnt  = 0;
      chk("rst_stall", int'(stall), 0);
      chk("rst_md_busy", int'(md_busy), 0);
      chk("rst_stall_cnt", int'(stall_cnt), 0);
      chk("rst_fwd", int'({fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt}), 0);
    end else begin
      busy = (cyc < md_done);
      es = blocked(int'(d_rs), int'(d_rs_tuse)) || blocked(int'(d_rt), int'(d_rt_tuse)) ||
           (d_md && busy);
      chk("stall", int'(stall), int'(es));
      chk("md_busy", int'(md_busy), int'(busy));
      chk("stall_cnt", int'(stall_cnt), m_scnt);
      chk("fwd_d_rs", int'(fwd_d_rs), efwd(int'(d_rs), 0));
      chk("fwd_d_rt", int'(fwd_d_rt), efwd(int'(d_rt), 0));
      chk("fwd_e_rs", int'(fwd_e_rs), efwd(h_rs[0], 1));
      chk("fwd_e_rt", int'(fwd_e_rt), efwd(h_rt[0], 1));
      chk("fwd_m_rt", int'(fwd_m_rt), efwd(h_rt[1], 2));
      // advance to the state after the coming rising edge
      for (int a = 2; a > 0; a--) begin
        h_rs[a] = h_rs[a-1]; h_rt[a] = h_rt[a-1]; h_dst[a] = h_dst[a-1]; h_tn[a] = h_tn[a-1];
      end
      if (es) begin
        h_rs[0] = 0; h_rt[0] = 0; h_dst[0] = 0; h_tn[0] = 0;
      end else begin
        h_rs[0] = int'(d_rs); h_rt[0] = int'(d_rt); h_dst[0] = int'(d_dst); h_tn[0] = int'(d_tnew);
      end
      if (d_md_start && !es) md_done = cyc + 1 + (d_md_div ? DIV : MULT);
      if (es && m_scnt < 65535) m_scnt++;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int rs, input int rt, input int rsu, input int rtu,
                       input int dst, input int tn, input bit md, input bit st, input bit dv);
    d_rs = AW'(rs); d_rt = AW'(rt); d_rs_tuse = TW'(rsu); d_rt_tuse = TW'(rtu);
    d_dst = AW'(dst); d_tnew = TW'(tn); d_md = md; d_md_start = st; d_md_div = dv;
  endtask

  initial begin
    int nb, ns;
    // reset with hostile D inputs: outputs must still be quiet
    drive(5, 6, 0, 0, 5, 3, 1, 0, 0);
    tick(); tick();
    chk("lit_rst_stall", int'(stall), 0);
    chk("lit_rst_fwd_d_rs", int'(fwd_d_rs), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // load-use: producer dst=8 tnew=2, consumer rs=8 tuse=1
    tick(); drive(0, 0, 0, 0, 8, 2, 0, 0, 0);
    tick(); drive(8, 0, 1, 0, 0, 0, 0, 0, 0); #1;
    chk("lit_lu_stall", int'(stall), 1);
    tick();
    chk("lit_lu_stall_released", int'(stall), 0);
    chk("lit_lu_fwd_d_rs", int'(fwd_d_rs), 0);
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("lit_lu_fwd_e_rs", int'(fwd_e_rs), 3);
    chk("lit_lu_stall_cnt", int'(stall_cnt), 1);

    // ALU chain on r9 filling E, then E+M, then E+M+W
    tick(); drive(0, 0, 0, 0, 9, 0, 0, 0, 0);
    tick(); drive(0, 9, 0, 0, 9, 0, 0, 0, 0); #1;
    chk("lit_alu_fwd_e", int'(fwd_d_rt), 1);
    chk("lit_alu_stall", int'(stall), 0);
    tick(); chk("lit_alu_fwd_em", int'(fwd_d_rt), 1);
    tick(); chk("lit_alu_fwd_emw", int'(fwd_d_rt), 1);

    // $0 is never a dependency
    drive(0, 0, 0, 0, 0, 3, 0, 0, 0);
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("lit_r0_stall", int'(stall), 0);
    chk("lit_r0_fwd", int'(fwd_d_rs), 0);

    // randomized traffic on a small register set to provoke hazards
    for (int i = 0; i < 2000; i++) begin
      bit md;
      tick();
      md = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3),
            md, md && ($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1);
    end

    // divide: 10 busy cycles, dependent MD op stalls 10 cycles
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); reset = 1'b1;
    tick(); reset = 1'b0;
    tick(); drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
    tick(); drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    nb = 0; ns = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (md_busy) nb++;
      if (stall) ns++;
      tick();
    end
    chk("lit_div_busy_cycles", nb, 10);
    chk("lit_div_stall_cycles", ns, 10);
    chk("lit_div_stall_cnt", int'(stall_cnt), 10);

    // reset three cycles into a multiply
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    tick(); drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick(); tick();
    chk("lit_mul_busy_before_rst", int'(md_busy), 1);
    reset = 1'b1; #1;
    chk("lit_mul_rst_busy", int'(md_busy), 0);
    chk("lit_mul_rst_stall", int'(stall), 0);
    chk("lit_mul_rst_stall_cnt", int'(stall_cnt), 0);
    tick(); reset = 1'b0;

    // back-to-back divides: 10 stalls out of every 11 cycles, until saturation
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
    repeat (72200) tick();
    chk("lit_sat_stall_cnt", int'(stall_cnt), 16'hFFFF);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
